muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer for the shared multi-cycle HI/LO arithmetic in the EX stage. It accepts one decoded HI/LO operation per instruction, runs the external iterative divider (and multiplier, when configured) through a start/ready handshake, and holds the pipeline with `stallreq_for_ex` until the result exists. It then emits the 65-bit `{we, hi, lo}` bus to MEM. It replaces the ad-hoc combinational divider control in EX; EX keeps only operand muxing and result forwarding.

## Interface
- No parameters; widths come from the shared package.
- `clk`  in  1  pipeline clock
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  `StallBus`  pipeline stall vector; bit 2 = EX hold, bit 3 = MEM hold
- `flush`  in  1  kill the in-flight op (exception/redirect)
- `op`  in  3  `MD_OP_*` code of the instruction currently in EX (`MD_OP_NONE` = not ours)
- `src_a`, `src_b`  in  32  rs / rt operand values (already forwarded)
- `hi_data`, `lo_data`  in  32  current architectural HI / LO (forwarded)
- `stallreq_for_ex`  out  1  hold request to the stall controller
- `div_start`, `div_signed`, `div_annul`  out  1  divider core controls
- `div_opdata1`, `div_opdata2`  out  32  dividend, divisor
- `div_ready`  in  1  one-cycle pulse: `div_result` valid
- `div_result`  in  64  `{remainder, quotient}`
- `mul_start`, `mul_signed`  out  1  and `mul_ina`, `mul_inb`  out  32; `mul_ready` in 1; `mul_result` in 64 (present only with `MULDIV_MUL_EN`)
- `ex_mem_lohi_bus`  out  65  `{we, hi, lo}` to MEM
- `busy_cycles`  out  6  cycles spent in the current BUSY state (debug/perf)

## Operation
- States: IDLE, DIV_BUSY, MUL_BUSY, DONE.
- **IDLE, DIV/DIVU, `src_b != 0`**
  - Latch operands and signedness.
  - `stallreq_for_ex` = 1 combinationally in the same cycle.
  - Next state DIV_BUSY.
- **IDLE, DIV/DIVU, `src_b == 0`**
  - No core start and no stall.
  - Bus = `{1, src_a, 32'hFFFF_FFFF}` this cycle.
  - Stay in IDLE.
- **IDLE, MULT/MULTU**
  - With `MULDIV_MUL_EN`: same as DIV, next state MUL_BUSY.
  - Without it: behaves as `MD_OP_NONE`.
- **IDLE, MTHI/MTLO:** bus = `{1, src_a, lo_data}` or `{1, hi_data, src_a}` this cycle, with no stall.
- **IDLE, NONE:** bus = `{0, hi_data, lo_data}`.
- **BUSY states**
  - Drive `start`, signedness and the latched operands every cycle.
  - `stallreq_for_ex` = 1.
  - `busy_cycles` increments, saturating at 63.
  - On `ready`, latch the result into the result register and go to DONE.
- **DONE**
  - `stallreq_for_ex` = 0.
  - Bus = `{1, result[63:32], result[31:0]}`.
  - Leave for IDLE only when `stall[2]` is NoStop, so the same instruction is never re-issued. Otherwise hold DONE with the bus stable.
- **Watchdog:** `busy_cycles` reaching 40 in a BUSY state means a core fault:
  - `div_annul` pulses for 1 cycle.
  - Next state DONE with `we` = 0 and HI/LO unchanged.
- **`flush` in any state**
  - `div_annul` = 1 for that cycle.
  - Bus `we` = 0 that cycle.
  - Next state IDLE; `stallreq_for_ex` drops the same cycle.
- **`rst`**
  - State IDLE and all latches zeroed.
  - `stallreq_for_ex`, all `start`, `annul` and `we` outputs = 0; `busy_cycles` = 0.
- **Precedence:** `rst` > `flush` > watchdog > `ready`.

## Timing
- Issue at cycle T: stall asserted at T; `start` first high at T+1.
- Core `ready` at cycle R: result on the bus and stall low at R+1. Total EX occupancy = R−T+2 cycles.
- Single-cycle ops (MTHI, MTLO, divide by zero) add 0 stall cycles.
- `ready` while in IDLE or DONE is ignored.
- `stall[3]` = Stop during DONE holds DONE, because `stall[2]` is also Stop.
- All state, latches and `busy_cycles` update on the rising edge of `clk`. Outputs are decoded from state plus `op`.

## Configuration
- `MULDIV_MUL_EN` defined:
  - The MUL_BUSY path and the `mul_*` ports exist.
  - MULT/MULTU stall until `mul_ready`, then write `{hi, lo}` = `mul_result`.
- Undefined:
  - The `mul_*` ports are absent and the MUL_BUSY state is not compiled.
  - MULT/MULTU produce `we` = 0 and no stall.

## Structure
- Shared package, added to `lib/defines.vh`:
  - `MD_OP_NONE` = 0, `DIV` = 1, `DIVU` = 2, `MULT` = 3, `MULTU` = 4, `MTHI` = 5, `MTLO` = 6.
  - State encodings.
  - `MD_WATCHDOG` = 40.
  - `LOHI_BUS_WD` = 65.
  - Existing `Stop`/`NoStop`, `DivStart`/`DivStop`.
- Sub-module `muldiv_opreg`: operand/sign latch plus result register with load/clear enables. The FSM stays in `muldiv_ctrl`.

## Test plan
- DIV `src_a` = −7, `src_b` = 2 → stall until `ready`, then bus = `{1, 32'hFFFF_FFFF, 32'hFFFF_FFFD}` for exactly 1 cycle and stall = 0 that cycle.
- DIVU `32'hFFFF_FFFF` / 16 → bus = `{1, 32'h0000_000F, 32'h0FFF_FFFF}`; `busy_cycles` equals the core latency.
- DIV with `src_b` = 0, `src_a` = 5 → no `div_start`, no stall, bus = `{1, 5, 32'hFFFF_FFFF}` the same cycle.
- MTHI `src_a` = `32'h1234`, `lo_data` = 9 → bus = `{1, 32'h1234, 9}`, stall never asserted.
- `flush` at the 3rd DIV_BUSY cycle → `div_annul` = 1, `we` = 0, IDLE next cycle. Repeat with `rst` instead: all outputs 0 the next cycle.
- Core never asserts `ready` → watchdog fires at cycle 40: annul pulse, DONE with `we` = 0, stall released.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared HI/LO sequencer codes, states and widths (MULDIV_MUL_EN adds MUL_BUSY)
package muldiv_ctrl_pkg;

  localparam int LOHI_BUS_WD  = 65;
  localparam int STALL_BUS_WD = 6;
  localparam int BUSY_CNT_WD  = 6;

  localparam logic [BUSY_CNT_WD-1:0] MD_WATCHDOG  = 6'd40;
  localparam logic [BUSY_CNT_WD-1:0] BUSY_CNT_MAX = 6'd63;

  localparam logic Stop     = 1'b1;
  localparam logic NoStop   = 1'b0;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  typedef logic [STALL_BUS_WD-1:0] StallBus;

  typedef enum logic [2:0] {
    MD_OP_NONE  = 3'd0,
    MD_OP_DIV   = 3'd1,
    MD_OP_DIVU  = 3'd2,
    MD_OP_MULT  = 3'd3,
    MD_OP_MULTU = 3'd4,
    MD_OP_MTHI  = 3'd5,
    MD_OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_BUSY = 2'd1,
`ifdef MULDIV_MUL_EN
    ST_MUL_BUSY = 2'd2,
`endif
    ST_DONE     = 2'd3
  } md_state_e;

  // Signed flavours of the multi-cycle ops
  function automatic logic md_op_signed(input logic [2:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_MULT);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - divider/multiplier core handshake (MULDIV_MUL_EN adds the multiplier signals)
interface muldiv_ctrl_if;

  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic        div_ready;
  logic [63:0] div_result;

`ifdef MULDIV_MUL_EN
  logic        mul_start;
  logic        mul_signed;
  logic [31:0] mul_ina;
  logic [31:0] mul_inb;
  logic        mul_ready;
  logic [63:0] mul_result;

  modport master (
    output div_start, div_signed, div_annul, div_opdata1, div_opdata2,
    output mul_start, mul_signed, mul_ina, mul_inb,
    input  div_ready, div_result, mul_ready, mul_result
  );
  modport slave (
    input  div_start, div_signed, div_annul, div_opdata1, div_opdata2,
    input  mul_start, mul_signed, mul_ina, mul_inb,
    output div_ready, div_result, mul_ready, mul_result
  );
`else
  modport master (
    output div_start, div_signed, div_annul, div_opdata1, div_opdata2,
    input  div_ready, div_result
  );
  modport slave (
    input  div_start, div_signed, div_annul, div_opdata1, div_opdata2,
    output div_ready, div_result
  );
`endif

endinterface

// File: rtl/muldiv_opreg.sv
// rtl/muldiv_opreg.sv - operand/sign latch and result register for the HI/LO sequencer
module muldiv_opreg (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_load,
  input  logic        op_signed_in,
  input  logic [31:0] op_a_in,
  input  logic [31:0] op_b_in,
  input  logic        res_load,
  input  logic        res_clear,
  input  logic [63:0] res_in,
  output logic        op_signed,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        res_valid,
  output logic [63:0] res
);

  // Operands and signedness captured at issue, held for the whole busy phase
  always_ff @(posedge clk) begin
    if (rst) begin
      op_signed <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
    end else if (op_load) begin
      op_signed <= op_signed_in;
      op_a      <= op_a_in;
      op_b      <= op_b_in;
    end
  end

  // Result register; clear wins so an aborted op never leaves a valid result behind
  always_ff @(posedge clk) begin
    if (rst || res_clear) begin
      res_valid <= 1'b0;
      res       <= '0;
    end else if (res_load) begin
      res_valid <= 1'b1;
      res       <= res_in;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - EX-stage HI/LO multi-cycle sequencer FSM (MULDIV_MUL_EN enables the multiplier path)
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  StallBus                stall,
  input  logic                   flush,
  input  logic [2:0]             op,
  input  logic [31:0]            src_a,
  input  logic [31:0]            src_b,
  input  logic [31:0]            hi_data,
  input  logic [31:0]            lo_data,
  output logic                   stallreq_for_ex,
  muldiv_ctrl_if.master          core,
  output logic [LOHI_BUS_WD-1:0] ex_mem_lohi_bus,
  output logic [BUSY_CNT_WD-1:0] busy_cycles
);

  md_state_e   state, state_nxt;
  logic        op_load, op_signed_nxt, res_load, res_clear;
  logic        lat_signed, res_valid, in_busy;
  logic [31:0] lat_a, lat_b, hi_out, lo_out;
  logic [63:0] res_q, res_in;
  logic        start_div, annul, we;
`ifdef MULDIV_MUL_EN
  logic        start_mul;
`endif

  // Only the EX hold bit decides when DONE may retire
  wire unused_stall = &{1'b0, stall[STALL_BUS_WD-1:3], stall[1:0]};

`ifdef MULDIV_MUL_EN
  assign in_busy = (state == ST_DIV_BUSY) || (state == ST_MUL_BUSY);
  assign res_in  = (state == ST_MUL_BUSY) ? core.mul_result : core.div_result;
`else
  assign in_busy = (state == ST_DIV_BUSY);
  assign res_in  = core.div_result;
`endif

  muldiv_opreg u_opreg (
    .clk          (clk),
    .rst          (rst),
    .op_load      (op_load),
    .op_signed_in (op_signed_nxt),
    .op_a_in      (src_a),
    .op_b_in      (src_b),
    .res_load     (res_load),
    .res_clear    (res_clear),
    .res_in       (res_in),
    .op_signed    (lat_signed),
    .op_a         (lat_a),
    .op_b         (lat_b),
    .res_valid    (res_valid),
    .res          (res_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Busy-cycle counter: restarts at issue, counts every BUSY cycle, saturates
  always_ff @(posedge clk) begin
    if (rst)
      busy_cycles <= '0;
    else if (op_load)
      busy_cycles <= '0;
    else if (in_busy && (busy_cycles != BUSY_CNT_MAX))
      busy_cycles <= busy_cycles + 6'd1;
  end

  // Next state and outputs; flush then reset override everything decoded above them
  always_comb begin
    state_nxt       = state;
    stallreq_for_ex = 1'b0;
    start_div       = DivStop;
    annul           = 1'b0;
    we              = 1'b0;
    hi_out          = hi_data;
    lo_out          = lo_data;
    op_load         = 1'b0;
    op_signed_nxt   = md_op_signed(op);
    res_load        = 1'b0;
    res_clear       = 1'b0;
`ifdef MULDIV_MUL_EN
    start_mul       = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        case (op)
          MD_OP_DIV, MD_OP_DIVU: begin
            if (src_b != 32'd0) begin
              op_load         = 1'b1;
              res_clear       = 1'b1;
              stallreq_for_ex = 1'b1;
              state_nxt       = ST_DIV_BUSY;
            end else begin
              we     = 1'b1;
              hi_out = src_a;
              lo_out = 32'hFFFF_FFFF;
            end
          end
`ifdef MULDIV_MUL_EN
          MD_OP_MULT, MD_OP_MULTU: begin
            op_load         = 1'b1;
            res_clear       = 1'b1;
            stallreq_for_ex = 1'b1;
            state_nxt       = ST_MUL_BUSY;
          end
`endif
          MD_OP_MTHI: begin
            we     = 1'b1;
            hi_out = src_a;
          end
          MD_OP_MTLO: begin
            we     = 1'b1;
            lo_out = src_a;
          end
          default: ;
        endcase
      end
      ST_DIV_BUSY: begin
        stallreq_for_ex = 1'b1;
        if (busy_cycles == MD_WATCHDOG) begin
          annul     = 1'b1;
          res_clear = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          start_div = DivStart;
          if (core.div_ready) begin
            res_load  = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
`ifdef MULDIV_MUL_EN
      ST_MUL_BUSY: begin
        stallreq_for_ex = 1'b1;
        if (busy_cycles == MD_WATCHDOG) begin
          annul     = 1'b1;
          res_clear = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          start_mul = 1'b1;
          if (core.mul_ready) begin
            res_load  = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
`endif
      ST_DONE: begin
        if (res_valid) begin
          we     = 1'b1;
          hi_out = res_q[63:32];
          lo_out = res_q[31:0];
        end
        if (stall[2] == NoStop) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      annul           = 1'b1;
      we              = 1'b0;
      stallreq_for_ex = 1'b0;
      start_div       = DivStop;
      op_load         = 1'b0;
      res_load        = 1'b0;
      res_clear       = 1'b0;
      state_nxt       = ST_IDLE;
`ifdef MULDIV_MUL_EN
      start_mul       = 1'b0;
`endif
    end
    if (rst) begin
      annul           = 1'b0;
      we              = 1'b0;
      stallreq_for_ex = 1'b0;
      start_div       = DivStop;
      op_load         = 1'b0;
      res_load        = 1'b0;
      res_clear       = 1'b0;
      state_nxt       = ST_IDLE;
`ifdef MULDIV_MUL_EN
      start_mul       = 1'b0;
`endif
    end
  end

  assign core.div_start   = start_div;
  assign core.div_signed  = (state == ST_DIV_BUSY) && lat_signed;
  assign core.div_annul   = annul;
  assign core.div_opdata1 = lat_a;
  assign core.div_opdata2 = lat_b;
`ifdef MULDIV_MUL_EN
  assign core.mul_start   = start_mul;
  assign core.mul_signed  = (state == ST_MUL_BUSY) && lat_signed;
  assign core.mul_ina     = lat_a;
  assign core.mul_inb     = lat_b;
`endif

  assign ex_mem_lohi_bus = {we, hi_out, lo_out};

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for the HI/LO sequencer against a behavioural divider model
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int WD_LIMIT = 40;

  logic        clk = 1'b0;
  logic        rst;
  StallBus     stall;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b, hi_data, lo_data;
  logic        stallreq_for_ex;
  logic [64:0] ex_mem_lohi_bus;
  logic [5:0]  busy_cycles;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  muldiv_ctrl_if core_if ();

  muldiv_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .op              (op),
    .src_a           (src_a),
    .src_b           (src_b),
    .hi_data         (hi_data),
    .lo_data         (lo_data),
    .stallreq_for_ex (stallreq_for_ex),
    .core            (core_if),
    .ex_mem_lohi_bus (ex_mem_lohi_bus),
    .busy_cycles     (busy_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every visible HI/LO write must match the oldest expected write
  always @(negedge clk) begin
    if (ex_mem_lohi_bus[64] === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%0h required=none", ex_mem_lohi_bus[63:0]);
      end else begin
        mon_e = exp_q.pop_front();
        if (ex_mem_lohi_bus[63:0] !== mon_e) begin
          errors++;
          $display("FAIL lohi_bus actual=%0h required=%0h", ex_mem_lohi_bus[63:0], mon_e);
        end
      end
    end
  end

  // Divide (or divide-by-zero); core answers after lat busy cycles; DONE held for hold extra cycles
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold);
    logic [31:0] q, r;
    op      = sgn ? MD_OP_DIV : MD_OP_DIVU;
    src_a   = a;
    src_b   = b;
    hi_data = $urandom;
    lo_data = $urandom;
    if (b == 32'd0) begin
      exp_q.push_back({a, 32'hFFFF_FFFF});
      @(negedge clk);
      chk("div0_stall", stallreq_for_ex, 0);
      chk("div0_start", core_if.div_start, 0);
      tick();
      op = MD_OP_NONE;
      @(negedge clk);
      chk("div0_no_busy_start", core_if.div_start, 0);
      tick();
      return;
    end
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    @(negedge clk);
    chk("issue_stall", stallreq_for_ex, 1);
    chk("issue_start", core_if.div_start, 0);
    for (int i = 1; i <= lat; i++) begin
      tick();
      if (i == lat) begin
        core_if.div_ready  = 1'b1;
        core_if.div_result = {r, q};
      end
      @(negedge clk);
      chk("busy_start", core_if.div_start, 1);
      chk("busy_stall", stallreq_for_ex, 1);
      chk("busy_opdata1", core_if.div_opdata1, a);
      chk("busy_opdata2", core_if.div_opdata2, b);
      chk("busy_signed", core_if.div_signed, sgn);
    end
    tick();
    core_if.div_ready  = 1'b0;
    core_if.div_result = {$urandom, $urandom};
    if (hold > 0) stall = 6'b001100;
    exp_q.push_back({r, q});
    @(negedge clk);
    chk("done_stall", stallreq_for_ex, 0);
    chk("done_busy_cycles", busy_cycles, lat);
    for (int k = 1; k <= hold; k++) begin
      tick();
      if (k == hold) stall = '0;
      core_if.div_ready = (k == 1);
      exp_q.push_back({r, q});
      @(negedge clk);
      chk("hold_stall", stallreq_for_ex, 0);
    end
    tick();
    core_if.div_ready = 1'b0;
    op = MD_OP_NONE;
    @(negedge clk);
    chk("after_stall", stallreq_for_ex, 0);
    chk("after_start", core_if.div_start, 0);
    tick();
  endtask

  task automatic do_mt(input logic to_hi, input logic [31:0] a, input logic [31:0] h,
                       input logic [31:0] l);
    op      = to_hi ? MD_OP_MTHI : MD_OP_MTLO;
    src_a   = a;
    hi_data = h;
    lo_data = l;
    exp_q.push_back(to_hi ? {a, l} : {h, a});
    @(negedge clk);
    chk("mt_stall", stallreq_for_ex, 0);
    chk("mt_start", core_if.div_start, 0);
    tick();
    op = MD_OP_NONE;
  endtask

  // Kill a divide in its 3rd busy cycle by flush or by reset
  task automatic do_abort(input logic use_rst);
    op    = MD_OP_DIV;
    src_a = $urandom;
    src_b = $urandom | 32'd1;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 3) begin
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
      end
    end
    @(negedge clk);
    if (use_rst) begin
      chk("rst_mid_stall", stallreq_for_ex, 0);
      chk("rst_mid_annul", core_if.div_annul, 0);
      chk("rst_mid_start", core_if.div_start, 0);
    end else begin
      chk("flush_annul", core_if.div_annul, 1);
      chk("flush_stall", stallreq_for_ex, 0);
      chk("flush_we", ex_mem_lohi_bus[64], 0);
    end
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    op    = MD_OP_NONE;
    @(negedge clk);
    chk("abort_stall", stallreq_for_ex, 0);
    chk("abort_start", core_if.div_start, 0);
    chk("abort_annul", core_if.div_annul, 0);
    chk("abort_we", ex_mem_lohi_bus[64], 0);
    if (use_rst) chk("abort_busy_cycles", busy_cycles, 0);
    tick();
  endtask

  task automatic do_watchdog();
    op    = MD_OP_DIVU;
    src_a = $urandom;
    src_b = $urandom | 32'd1;
    @(negedge clk);
    chk("wd_issue_stall", stallreq_for_ex, 1);
    for (int i = 1; i <= WD_LIMIT + 1; i++) begin
      tick();
      @(negedge clk);
      if (i == WD_LIMIT) chk("wd_early_annul", core_if.div_annul, 0);
      if (i == WD_LIMIT + 1) begin
        chk("wd_annul", core_if.div_annul, 1);
        chk("wd_fire_stall", stallreq_for_ex, 1);
      end
    end
    tick();
    @(negedge clk);
    chk("wd_done_stall", stallreq_for_ex, 0);
    chk("wd_done_annul", core_if.div_annul, 0);
    chk("wd_done_we", ex_mem_lohi_bus[64], 0);
    tick();
    op = MD_OP_NONE;
    @(negedge clk);
    chk("wd_idle_start", core_if.div_start, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    int          kind, lat, hold;
    rst     = 1'b1;
    stall   = '0;
    flush   = 1'b0;
    op      = MD_OP_NONE;
    src_a   = '0;
    src_b   = '0;
    hi_data = '0;
    lo_data = '0;
    core_if.div_ready  = 1'b0;
    core_if.div_result = '0;
`ifdef MULDIV_MUL_EN
    core_if.mul_ready  = 1'b0;
    core_if.mul_result = '0;
`endif
    repeat (2) tick();
    @(negedge clk);
    chk("rst_stall", stallreq_for_ex, 0);
    chk("rst_start", core_if.div_start, 0);
    chk("rst_annul", core_if.div_annul, 0);
    chk("rst_we", ex_mem_lohi_bus[64], 0);
    chk("rst_busy_cycles", busy_cycles, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_bus", ex_mem_lohi_bus, 65'd0);
    tick();

    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 5, 0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd16, 8, 0);
    do_div(1'b1, 32'd5, 32'd0, 1, 0);
    do_mt(1'b1, 32'h1234, $urandom, 32'd9);
    do_mt(1'b0, 32'hCAFE_0001, 32'h7777, $urandom);

`ifndef MULDIV_MUL_EN
    op = MD_OP_MULT;
    @(negedge clk);
    chk("mult_off_stall", stallreq_for_ex, 0);
    tick();
    op = MD_OP_NONE;
`endif

    core_if.div_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready_stall", stallreq_for_ex, 0);
    tick();
    core_if.div_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready_start", core_if.div_start, 0);
    tick();

    do_abort(1'b0);
    do_abort(1'b1);
    do_watchdog();
    do_div(1'b1, 32'd100, 32'hFFFF_FFF9, 3, 2);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      lat  = $urandom_range(1, 6);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      ra   = $urandom;
      rb   = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 40) : $urandom;
      if (rb == 32'hFFFF_FFFF) rb = 32'd7;
      case (kind)
        0: do_div(1'b1, ra, rb, lat, hold);
        1: do_div(1'b0, ra, rb, lat, hold);
        2: do_div($urandom_range(0, 1) == 1, ra, 32'd0, 1, 0);
        3: do_mt(1'b1, ra, $urandom, $urandom);
        4: do_mt(1'b0, ra, $urandom, $urandom);
        default: begin
          op = MD_OP_NONE;
          @(negedge clk);
          chk("rand_idle_stall", stallreq_for_ex, 0);
          tick();
        end
      endcase
    end

    op = MD_OP_NONE;
    repeat (2) tick();
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
